// File: rtl/mips_hilo_muldiv.sv
// mips_hilo_muldiv: multi-cycle MIPS multiply/divide unit with architectural HI/LO registers
module mips_hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] m, hw, lw, abs_a, abs_b;
  logic [4:0] cnt;
  logic is_div, dz, neg_q, neg_r, mul_op, div_op, sgn, go, b_zero;
  logic [WIDTH:0] sum, sh;
  logic [WIDTH+1:0] diff;
  logic [2*WIDTH-1:0] prod;
  assign mul_op = op == 3'd1 || op == 3'd2;
  assign div_op = op == 3'd3 || op == 3'd4;
  assign sgn = op == 3'd1 || op == 3'd3;
  assign b_zero = b == '0;
  assign go = start && state == IDLE && (mul_op || div_op);
  assign abs_a = sgn && a[WIDTH-1] ? -a : a;
  assign abs_b = sgn && b[WIDTH-1] ? -b : b;
  assign sum = {1'b0, hw} + {1'b0, m};
  assign sh = {hw, lw[WIDTH-1]};
  assign diff = {1'b0, sh} - {2'b0, m};
  assign prod = neg_q ? -{hw, lw} : {hw, lw};
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state == IDLE ? (go ? (div_op && b_zero ? FINISH : RUN) : IDLE) :
               state == RUN  ? (cnt == 5'd0 ? FINISH : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nx;
  end
  always_ff @(posedge clk) begin
    if (go) begin
      m      <= abs_b;
      lw     <= abs_a;
      hw     <= div_op && b_zero ? a : '0;
      is_div <= div_op;
      dz     <= div_op && b_zero;
      neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= sgn && a[WIDTH-1];
      cnt    <= 5'd31;
    end else if (state == RUN) begin
      cnt <= cnt - 5'd1;
      if (is_div)
        {hw, lw} <= diff[WIDTH+1] ? {sh[WIDTH-1:0], lw[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], lw[WIDTH-2:0], 1'b1};
      else
        {hw, lw} <= lw[0] ? {sum, lw[WIDTH-1:1]} : {1'b0, hw, lw[WIDTH-1:1]};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= state == FINISH;
      if (start && state == IDLE && op == 3'd5) hi <= a;
      if (start && state == IDLE && op == 3'd6) lo <= a;
      if (state == FINISH) begin
        hi <= dz ? hw : is_div ? (neg_r ? -hw : hw) : prod[2*WIDTH-1:WIDTH];
        lo <= dz ? '1 : is_div ? (neg_q ? -lw : lw) : prod[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mips_hilo_muldiv.sv
// tb_mips_hilo_muldiv: directed self-checking bench for the HI/LO multiply/divide unit
module tb_mips_hilo_muldiv;
  logic clk = 1'b0, rst, start, busy, done;
  logic [2:0] op;
  logic [31:0] a, b, hi, lo;
  int n_chk = 0, n_fail = 0, nb;
  logic seen;
  mips_hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (busy) n++;
      @(negedge clk);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eh, input logic [31:0] el, input int eb);
    int n;
    issue(o, x, y);
    wait_done(n);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_cycles"}, n, eb);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    @(negedge clk);
    check({tag, "_done_drop"}, done, 0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    issue(3'd5, 32'h12345678, 32'h0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo", lo, 0);
    check("mthi_busy", busy, 0);
    check("mthi_done", done, 0);
    issue(3'd6, 32'hCAFEF00D, 32'h0);
    check("mtlo_lo", lo, 32'hCAFEF00D);
    check("mtlo_hi", hi, 32'h12345678);
    issue(3'd0, 32'h1, 32'h1);
    issue(3'd7, 32'h2, 32'h2);
    check("nop_hi", hi, 32'h12345678);
    check("nop_lo", lo, 32'hCAFEF00D);
    check("nop_busy", busy, 0);
    run("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    run("mult_neg", 3'd1, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
    run("mult_minmin", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 33);
    run("mult_m1m1", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 33);
    run("div_neg", 3'd3, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run("divu", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
    run("div_negdiv", 3'd3, 32'd7, -32'sd2, 32'd1, 32'hFFFFFFFD, 33);
    run("divu_zero", 3'd4, 32'h55, 32'h0, 32'h55, 32'hFFFFFFFF, 1);
    run("div_zero", 3'd3, 32'hFFFFFF00, 32'h0, 32'hFFFFFF00, 32'hFFFFFFFF, 1);
    issue(3'd1, 32'h1234, 32'h10);
    start = 1'b1;
    op = 3'd6;
    a = 32'hDEAD;
    @(negedge clk);
    op = 3'd3;
    a = 32'd9;
    b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    a = 32'h7777;
    b = 32'h9999;
    wait_done(nb);
    check("ign_done", done, 1);
    check("ign_busy_cycles", nb, 31);
    check("ign_hi", hi, 0);
    check("ign_lo", lo, 32'h12340);
    issue(3'd4, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin
      seen |= done | busy;
      @(negedge clk);
    end
    check("abort_no_done", seen, 0);
    run("multu_small", 3'd2, 32'd3, 32'd5, 32'd0, 32'd15, 33);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
